pipelined_prefix_adder: RTL and testbench

PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

---
 rtl/prefix_adder_pkg.sv | 16 +
 rtl/prefix_level.sv | 26 ++
 rtl/pipelined_prefix_adder.sv | 135 +++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_adder_pkg.sv
// Shared types and sizing helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of registered prefix stages needed to cover all log2(width) levels.
  function automatic int calc_nstg(input int width, input int levels_per_stage);
    int levels;
    levels = $clog2(width);
    return (levels + levels_per_stage - 1) / levels_per_stage;
  endfunction

endpackage

// File: rtl/prefix_level.sv
// One combinational Kogge-Stone level: every bit combines with the group SPAN bits below it.
module prefix_level #(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi >= SPAN) begin : g_black
        assign g_out[gi] = g_in[gi] | (p_in[gi] & g_in[gi-SPAN]);
        assign p_out[gi] = p_in[gi] & p_in[gi-SPAN];
      end else begin : g_gray
        // Group already reaches the carry-in, so its generate is final.
        assign g_out[gi] = g_in[gi];
        assign p_out[gi] = p_in[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and whole-pipe stall.
// Optional signed-overflow output enabled by defining PREFIX_ADDER_OVF_EN.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PREFIX_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int NSTG   = calc_nstg(WIDTH, LEVELS_PER_STAGE);

  op_e              op_sel;
  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] carry;

  // Rank 0 holds the bitwise P/G; rank s+1 holds the output of prefix stage s.
  logic [NSTG:0]    valid_reg;
  logic [NSTG:0]    cin_reg;
  logic [WIDTH-1:0] g_reg [0:NSTG];
  logic [WIDTH-1:0] p_reg [0:NSTG];
  logic [WIDTH-1:0] x_reg [0:NSTG];

  logic [WIDTH-1:0] lvl_g_in  [0:LEVELS-1];
  logic [WIDTH-1:0] lvl_p_in  [0:LEVELS-1];
  logic [WIDTH-1:0] lvl_g_out [0:LEVELS-1];
  logic [WIDTH-1:0] lvl_p_out [0:LEVELS-1];
  logic [WIDTH-1:0] stage_g   [0:NSTG-1];
  logic [WIDTH-1:0] stage_p   [0:NSTG-1];

  assign op_sel   = op_e'(op);
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  // Carry-in is folded into bit 0's generate so the tree needs only log2(WIDTH) levels.
  always_comb begin
    b_eff = (op_sel == OP_SUB) ? ~b : b;
    c_eff = (op_sel == OP_SUB) ? 1'b1 : cin;
    x0    = a ^ b_eff;
    g0    = a & b_eff;
    g0[0] = (a[0] & b_eff[0]) | (x0[0] & c_eff);
  end

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      if (gi % LEVELS_PER_STAGE == 0) begin : g_from_reg
        assign lvl_g_in[gi] = g_reg[gi / LEVELS_PER_STAGE];
        assign lvl_p_in[gi] = p_reg[gi / LEVELS_PER_STAGE];
      end else begin : g_from_prev
        assign lvl_g_in[gi] = lvl_g_out[gi-1];
        assign lvl_p_in[gi] = lvl_p_out[gi-1];
      end

      prefix_level #(
        .WIDTH (WIDTH),
        .SPAN  (1 << gi)
      ) u_level (
        .g_in  (lvl_g_in[gi]),
        .p_in  (lvl_p_in[gi]),
        .g_out (lvl_g_out[gi]),
        .p_out (lvl_p_out[gi])
      );
    end

    for (gi = 0; gi < NSTG; gi++) begin : g_stage
      localparam int LAST = ((gi + 1) * LEVELS_PER_STAGE < LEVELS) ?
                            (gi + 1) * LEVELS_PER_STAGE - 1 : LEVELS - 1;
      assign stage_g[gi] = lvl_g_out[LAST];
      assign stage_p[gi] = lvl_p_out[LAST];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (advance) begin
      g_reg[0]   <= g0;
      p_reg[0]   <= x0;
      x_reg[0]   <= x0;
      cin_reg[0] <= c_eff;
      for (int s = 0; s < NSTG; s++) begin
        g_reg[s+1]   <= stage_g[s];
        p_reg[s+1]   <= stage_p[s];
        x_reg[s+1]   <= x_reg[s];
        cin_reg[s+1] <= cin_reg[s];
      end
    end
  end

  assign carry = {g_reg[NSTG][WIDTH-2:0], cin_reg[NSTG]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PREFIX_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (advance) begin
      valid_reg <= {valid_reg[NSTG-1:0], in_valid};
      out_valid <= valid_reg[NSTG];
      // Hold the last result across bubbles so unreset data never reaches the port.
      if (valid_reg[NSTG]) begin
        sum  <= x_reg[NSTG] ^ carry;
        cout <= g_reg[NSTG][WIDTH-1];
`ifdef PREFIX_ADDER_OVF_EN
        ovf  <= carry[WIDTH-1] ^ g_reg[NSTG][WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Self-checking bench for pipelined_prefix_adder at default parameters (scoreboard + vector table).
module tb_pipelined_prefix_adder;

  localparam int W       = 32;
  localparam int EXP_LAT = 4;
  localparam int NVEC    = 10;

  typedef logic [W+1:0] exp_t;   // {ovf, cout, sum}

  typedef struct {
    bit           op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           cin;
    logic [W-1:0] sum;
    bit           cout;
    bit           ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef PREFIX_ADDER_OVF_EN
  logic         ovf;
`endif

  pipelined_prefix_adder #(
    .WIDTH            (W),
    .LEVELS_PER_STAGE (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PREFIX_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  exp_t sb_q[$];
  exp_t pend_exp;
  vec_t vecs[NVEC];

  task automatic check(input bit ok, input string msg);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  // Behavioural reference built on the + operator and operand sign rules.
  function automatic exp_t ref_model(input bit o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                                     input bit ci);
    logic [W-1:0] bb;
    logic [W:0]   full;
    bit           c;
    bit           v;
    bb   = o ? ~bi : bi;
    c    = o ? 1'b1 : ci;
    full = {1'b0, ai} + {1'b0, bb} + {{W{1'b0}}, c};
    v    = (ai[W-1] == bb[W-1]) && (full[W-1] != ai[W-1]);
    return {v, full};
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_sum;
  logic         prev_cout;
  exp_t         got_v;
  exp_t         want_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check(out_valid && sum == prev_sum && cout == prev_cout,
              $sformatf("stall hold: out_valid=%b sum=%h cout=%b, want out_valid=1 sum=%h cout=%b",
                        out_valid, sum, cout, prev_sum, prev_cout));
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_cout  = cout;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check(1'b0, $sformatf("result unexpected: got sum=%h cout=%b, want no result", sum, cout));
        end else begin
          want_v = sb_q.pop_front();
`ifdef PREFIX_ADDER_OVF_EN
          got_v  = {ovf, cout, sum};
`else
          got_v  = {1'b0, cout, sum};
          want_v[W+1] = 1'b0;
`endif
          check(got_v == want_v, $sformatf("result #%0d: got ovf/cout/sum=%b/%b/%h, want %b/%b/%h",
                n_out, got_v[W+1], got_v[W], got_v[W-1:0], want_v[W+1], want_v[W], want_v[W-1:0]));
          n_out++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(pend_exp);
    end
  end

  task automatic send_beat(input bit o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                           input bit ci, input exp_t e);
    bit acc;
    int guard;
    guard    = 0;
    op       = o;
    a        = ai;
    b        = bi;
    cin      = ci;
    pend_exp = e;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check(1'b0, $sformatf("send timeout: in_ready=%b, want 1", in_ready));
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    bit           o;
    logic [W-1:0] ai;
    logic [W-1:0] bi;
    bit           ci;
    o  = 1'($urandom_range(0, 1));
    ci = 1'($urandom_range(0, 1));
    ai = $urandom();
    bi = $urandom();
    case ($urandom_range(0, 7))
      0: ai = '1;
      1: bi = 32'h8000_0000;
      2: ai = 32'h7FFF_FFFF;
      3: bi = '0;
      default: ;
    endcase
    send_beat(o, ai, bi, ci, ref_model(o, ai, bi, ci));
  endtask

  task automatic latency_beat(input bit o, input logic [W-1:0] ai, input logic [W-1:0] bi,
                              input bit ci, input exp_t e, input string name);
    int cyc;
    send_beat(o, ai, bi, ci, e);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(cyc == EXP_LAT, $sformatf("%s latency: got %0d cycles, want %0d", name, cyc, EXP_LAT));
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(sb_q.size() == 0, $sformatf("%s drain: got %0d results outstanding, want 0", name, sb_q.size()));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n0;
    int  stale;
    bit  done;
    logic [W-1:0] held;

    vecs[0] = '{1'b0, 32'd25,         32'd75,         1'b1, 32'd101,        1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'd5,          32'd7,          1'b0, 32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF,  1'b1, 1'b1};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'd7,          32'd5,          1'b1, 32'd2,          1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'd0,          32'd0,          1'b0, 32'd0,          1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd0,          1'b1, 32'd0,          1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'd0,          32'd0,          1'b0, 32'd0,          1'b1, 1'b0};
    vecs[9] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0,          1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op        = 1'b0;
    out_ready = 1'b1;
    pend_exp  = '0;

    repeat (3) @(posedge clk);
    #1;
    check(!out_valid && sum == '0 && !cout,
          $sformatf("reset state: out_valid=%b sum=%h cout=%b, want 0/0/0", out_valid, sum, cout));
    check(in_ready, $sformatf("reset in_ready: got %b, want 1", in_ready));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    latency_beat(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].cin,
                 {vecs[0].ovf, vecs[0].cout, vecs[0].sum}, "first beat");
    wait_drain("first beat");

    for (int i = 0; i < NVEC; i++)
      send_beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
    wait_drain("vector table");

    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid && g < 40);
        check(out_valid, "stall setup: out_valid=0, want 1");
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check(!in_ready && out_valid,
                $sformatf("stall cycle %0d: in_ready=%b out_valid=%b, want 0/1", k, in_ready, out_valid));
          if (k == 0) held = sum;
          else check(sum == held, $sformatf("stall cycle %0d sum: got %h, want %h", k, sum, held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("stall stream");
    check(n_out - n0 == 8, $sformatf("stall stream count: got %0d results, want 8", n_out - n0));

    n0 = n_out;
    for (int i = 0; i < 3; i++) send_rand();
    repeat (2) @(posedge clk);
    #1;
    check(out_valid, $sformatf("pre-reset out_valid: got %b, want 1", out_valid));
    rst_n = 1'b0;
    #1;
    check(!out_valid && in_ready,
          $sformatf("reset in flight: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check(stale == 0 && n_out == n0,
          $sformatf("post-reset stale: got %0d valid cycles, %0d results, want 0/0", stale, n_out - n0));
    @(posedge clk);
    #1;
    latency_beat(vecs[3].op, vecs[3].a, vecs[3].b, vecs[3].cin,
                 {vecs[3].ovf, vecs[3].cout, vecs[3].sum}, "post-reset");
    wait_drain("post-reset");

    n0   = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("random");
    check(n_out - n0 == 1500, $sformatf("random count: got %0d results, want 1500", n_out - n0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
